// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the unified memory.
// Owns the PC, captures the combinationally returned instruction word into
// a two-entry queue and hands {pc, inst} to decode over valid/ready.
// Optional build macro: FETCH_PERF_CNT_EN adds fetch_count / stall_count.
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head_inst_q, head_inst_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic [DATA_W-1:0] tail_inst_q, tail_inst_d;
    logic [ADDR_W-1:0] tail_pc_q, tail_pc_d;

    logic pop;
    logic redirect;
    logic can_accept;
    logic push;

    // A pop is a completed handshake with decode; a full queue can still
    // accept a new word when the head leaves in the same cycle. A taken
    // branch blocks the fetch because pc is about to be replaced.
    always_comb begin
        pop        = (count_q != 2'd0) && out_ready;
        redirect   = branch_taken && (state_q != ST_IDLE);
        can_accept = (count_q != 2'd2) || pop;
        push       = (state_q == ST_RUN) && !branch_taken && can_accept;
    end

    // Control state machine: IDLE waits for start, RUN fetches, HALTED
    // lets the queue drain and resumes on start or on a redirect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (start || branch_taken) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // PC update: a redirect wins over sequential advance; otherwise pc only
    // moves when the current word was actually pushed (wraps naturally).
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = branch_target;
        end else if (push) begin
            pc_d = pc_q + PC_ONE;
        end
    end

    // Two-entry FIFO kept as head/tail registers so the head drives the
    // outputs straight from flops. A redirect flushes everything and drops
    // any pop happening in the same cycle.
    always_comb begin
        count_d     = count_q;
        head_inst_d = head_inst_q;
        head_pc_d   = head_pc_q;
        tail_inst_d = tail_inst_q;
        tail_pc_d   = tail_pc_q;
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_inst_d = inst;
                        head_pc_d   = pc_q;
                    end else begin
                        tail_inst_d = inst;
                        tail_pc_d   = pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_inst_d = tail_inst_q;
                    head_pc_d   = tail_pc_q;
                    count_d     = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_inst_d = inst;
                        head_pc_d   = pc_q;
                    end else begin
                        head_inst_d = tail_inst_q;
                        head_pc_d   = tail_pc_q;
                        tail_inst_d = inst;
                        tail_pc_d   = pc_q;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // State, PC and queue registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= PC_RESET;
            count_q     <= 2'd0;
            head_inst_q <= '0;
            head_pc_q   <= '0;
            tail_inst_q <= '0;
            tail_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            head_inst_q <= head_inst_d;
            head_pc_q   <= head_pc_d;
            tail_inst_q <= tail_inst_d;
            tail_pc_q   <= tail_pc_d;
        end
    end

    assign pc        = pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_inst  = head_inst_q;
    assign out_pc    = head_pc_q;
    assign busy      = (state_q == ST_RUN);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Performance counters: pushes, and RUN cycles lost to a full queue.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (push) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if ((state_q == ST_RUN) && (count_q == 2'd2) && !pop && !branch_taken) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset and wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a behavioural memory returning
// mem[pc] combinationally. Expected values are hand-computed constants.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt_req;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  pc;
    logic [31:0] inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [7:0]  out_pc;
    logic        busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    logic [31:0] mem [0:255];

    int checks;
    int errors;

    fetch_unit #(
        .ADDR_W(8),
        .DATA_W(32),
        .RESET_PC(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .halt_req(halt_req),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .pc(pc),
        .inst(inst),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst(out_inst),
        .out_pc(out_pc),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fetch_count),
        .stall_count(stall_count),
`endif
        .busy(busy)
    );

    assign inst = mem[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the control inputs for the next edge.
    task automatic applyStimulus(input logic s, input logic h, input logic b, input logic [7:0] t, input logic r);
        start         = s;
        halt_req      = h;
        branch_taken  = b;
        branch_target = t;
        out_ready     = r;
    endtask

    // Hold reset low for one edge, then release it.
    task automatic doReset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hC000_0000 | i;
        end
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;

        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        tick();
        tick();

        // Reset state.
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_pc", {24'd0, pc}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_inst", out_inst, 32'd0);
        checkOutput("rst_outpc", {24'd0, out_pc}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("rst_fetch_cnt", fetch_count, 32'd0);
        checkOutput("rst_stall_cnt", stall_count, 32'd0);
`endif
        rst = 1'b1;

        // Streaming with decode always ready.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("s_busy", {31'd0, busy}, 32'd1);
        checkOutput("s_valid_pre", {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput("s_valid0", {31'd0, out_valid}, 32'd1);
        checkOutput("s_inst0", out_inst, 32'h11);
        checkOutput("s_pc0", {24'd0, out_pc}, 32'd0);
        tick();
        checkOutput("s_inst1", out_inst, 32'h22);
        checkOutput("s_pc1", {24'd0, out_pc}, 32'd1);
        tick();
        checkOutput("s_inst2", out_inst, 32'h33);
        checkOutput("s_pc2", {24'd0, out_pc}, 32'd2);
        tick();
        checkOutput("s_inst3", out_inst, 32'h44);
        checkOutput("s_pc3", {24'd0, out_pc}, 32'd3);

        // Backpressure: queue fills, pc holds, order preserved on release.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("bp_pc_hold", {24'd0, pc}, 32'd2);
        checkOutput("bp_inst_hold", out_inst, 32'h11);
        checkOutput("bp_outpc_hold", {24'd0, out_pc}, 32'd0);
        tick();
        checkOutput("bp_pc_hold2", {24'd0, pc}, 32'd2);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_inst1", out_inst, 32'h22);
        checkOutput("bp_outpc1", {24'd0, out_pc}, 32'd1);
        checkOutput("bp_pc3", {24'd0, pc}, 32'd3);
        tick();
        checkOutput("bp_inst2", out_inst, 32'h33);
        checkOutput("bp_outpc2", {24'd0, out_pc}, 32'd2);
        tick();
        checkOutput("bp_outpc3", {24'd0, out_pc}, 32'd3);
        checkOutput("bp_pc5", {24'd0, pc}, 32'd5);

        // Redirect while streaming at pc 5.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h40, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("br_valid_low", {31'd0, out_valid}, 32'd0);
        checkOutput("br_pc", {24'd0, pc}, 32'h40);
        tick();
        checkOutput("br_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("br_outpc", {24'd0, out_pc}, 32'h40);
        checkOutput("br_inst", out_inst, 32'hC000_0040);
        tick();
        checkOutput("br_outpc_next", {24'd0, out_pc}, 32'h41);

        // Halt at pc 3, drain, resume at pc 4.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("h_pc_at3", {24'd0, pc}, 32'd3);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checkOutput("h_busy", {31'd0, busy}, 32'd0);
        checkOutput("h_pc4", {24'd0, pc}, 32'd4);
        checkOutput("h_last_outpc", {24'd0, out_pc}, 32'd3);
        checkOutput("h_last_valid", {31'd0, out_valid}, 32'd1);
        tick();
        checkOutput("h_drained", {31'd0, out_valid}, 32'd0);
        checkOutput("h_pc_stay", {24'd0, pc}, 32'd4);
        tick();
        checkOutput("h_pc_stay2", {24'd0, pc}, 32'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("h_resume_busy", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("h_resume_outpc", {24'd0, out_pc}, 32'd4);
        checkOutput("h_resume_inst", out_inst, 32'hC000_0004);

        // PC wrap from 0xFF to 0x00.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("w_outpc_ff", {24'd0, out_pc}, 32'hFF);
        checkOutput("w_pc_wrap", {24'd0, pc}, 32'h00);
        tick();
        checkOutput("w_outpc_00", {24'd0, out_pc}, 32'h00);
        checkOutput("w_inst_00", out_inst, 32'h11);
        tick();
        checkOutput("w_outpc_01", {24'd0, out_pc}, 32'h01);

        // Reset mid-stream while out_valid is high.
        checkOutput("r_valid_before", {31'd0, out_valid}, 32'd1);
        doReset();
        checkOutput("r_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("r_pc", {24'd0, pc}, 32'd0);
        checkOutput("r_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        checkOutput("r_nofetch_pc", {24'd0, pc}, 32'd0);
        checkOutput("r_nofetch_valid", {31'd0, out_valid}, 32'd0);

        // Start with halt in IDLE runs; then branch plus halt in RUN.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("sh_busy", {31'd0, busy}, 32'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h10, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("bh_busy", {31'd0, busy}, 32'd0);
        checkOutput("bh_pc", {24'd0, pc}, 32'h10);
        checkOutput("bh_valid", {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput("bh_pc_hold", {24'd0, pc}, 32'h10);

        // Redirect from HALTED restarts fetching at the target.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h20, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("hb_busy", {31'd0, busy}, 32'd1);
        checkOutput("hb_pc", {24'd0, pc}, 32'h20);
        tick();
        checkOutput("hb_outpc", {24'd0, out_pc}, 32'h20);
        checkOutput("hb_inst", out_inst, 32'hC000_0020);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the unified instruction/data memory.
- Owns the program counter and drives the memory's instruction address.
- Captures the combinationally returned instruction word into a 2-entry instruction queue.
- Presents {pc, instruction} to the decode stage over a valid/ready handshake; handles branch redirect, halt and start control.

Parameters:
- ADDR_W, 8, width of PC / memory word address (256 words)
- DATA_W, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- start  input  1  begin/resume fetching (pulse)
- halt_req  input  1  stop issuing new fetches
- branch_taken  input  1  redirect request from execute
- branch_target  input  ADDR_W  redirect address
- pc  output  ADDR_W  instruction address to memory
- inst  input  DATA_W  instruction word from memory, combinational on pc
- out_valid  output  1  head of queue valid
- out_ready  input  1  decode accepts head
- out_inst  output  DATA_W  head instruction
- out_pc  output  ADDR_W  PC of head instruction
- busy  output  1  state is RUN

Behaviour:
- Reset (rst==0 at posedge):
  - pc=RESET_PC, queue count=0, out_valid=0, out_inst=0, out_pc=0, busy=0, state=IDLE.
  - Reset mid-operation discards queue contents and any pending redirect.
- States: IDLE, RUN, HALTED.
  - IDLE: start -> RUN; branch_taken and halt_req ignored; no fetch.
  - RUN: halt_req -> HALTED.
  - HALTED: start -> RUN, continuing from current pc; branch_taken -> RUN with redirect.
- Fetch (RUN only):
  - When the queue can accept, and no branch is taken that cycle, push {pc, inst} and set pc <= pc+1.
  - The queue can accept when count<2, or count==2 and a pop occurs in the same cycle.
  - pc wraps from 2^ADDR_W-1 to 0.
- Halt:
  - A fetch still occurs in the cycle halt_req is sampled in RUN; no fetches thereafter.
  - The queue drains normally while HALTED.
- Queue:
  - FIFO, depth 2; out_valid = (count!=0); out_inst/out_pc = head entry (registered).
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop at count 1 or 2 keeps the count unchanged and preserves order.
  - Push when full without a pop never occurs (fetch stalls, pc holds).
- Redirect (branch_taken in RUN or HALTED):
  - Queue flushed to count=0 and pc <= branch_target in the same edge.
  - No push that cycle; any pop that cycle is discarded (decode must tolerate this).
  - out_valid=0 in the following cycle.
  - First fetch from the target occurs in the following cycle; the target instruction is valid at out_* two edges after the branch.
- Simultaneous events:
  - branch_taken + halt_req in RUN: flush, pc=branch_target, state=HALTED.
  - start + halt_req in IDLE: -> RUN (halt ignored in IDLE).
- Latency: instruction at address A appears on out_* one edge after pc==A is fetched.
- Throughput: one instruction per cycle while out_ready is held high.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs fetch_count (32-bit) and stall_count (32-bit), both reset to 0.
  - fetch_count increments on every push.
  - stall_count increments each RUN cycle where the queue is full, with no pop and no branch.
  - Both wrap at 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, start, out_ready=1, mem[0..3]=0x11,0x22,0x33,0x44 -> out_inst 0x11,0x22,0x33,0x44 on consecutive cycles with out_pc 0,1,2,3; out_valid low before the first.
- out_ready=0 after start -> queue fills with pc 0,1; pc holds at 2; out_inst stays mem[0] until out_ready=1, then mem[1] then mem[2] in order, no loss or duplication.
- While streaming at pc=5, branch_taken=1, branch_target=0x40 -> out_valid=0 next cycle; next valid out_pc=0x40 with mem[0x40]; no instruction from pc 5/6 emitted after the flush.
- halt_req at pc=3 -> busy=0, pc stops at 4, queued entries drain; start -> fetch resumes at pc 4.
- branch_target=0xFF then stream -> out_pc sequence 0xFF, 0x00, 0x01 (wrap).
- rst=0 for one edge mid-stream with out_valid=1 -> out_valid=0, pc=RESET_PC, state IDLE; no fetch until start.
